// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO read data to a downstream consumer.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side stage: issues RAM reads and presents the returned words as a
// first-word-fall-through stream through a 2-entry head/skid buffer.
module fifo_rd_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              r_clk,
  input  logic              rst,
  input  logic              r_empty,
  output logic              r_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  fifo_rd_stream_if.master  m,
  output logic [1:0]        occ
);

  logic [1:0]        occ_q;
  logic              inflight_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] skid_q;
  logic              pop;
  logic              accept;
  logic [2:0]        fill_next;

  // fill_next cannot underflow: pop requires occ_q >= 1.
  always_comb begin
    pop       = m.m_valid & m.m_ready;
    fill_next = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    r_en      = ~rst & ~flush & ~r_empty & (fill_next < 3'(BUF_DEPTH));
    accept    = r_en & ~r_empty;
  end

  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = head_q;
  assign occ       = occ_q;

  always_ff @(posedge r_clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= fill_next[1:0];
      inflight_q <= accept;
      case (occ_q)
        2'd0: if (inflight_q) head_q <= rd_data;
        2'd1: begin
          if (inflight_q) begin
            if (pop) head_q <= rd_data;
            else     skid_q <= rd_data;
          end
        end
        // A full buffer blocks reads, so no capture can coincide with this.
        2'd2: if (pop) head_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule
